cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the RV32I data path. Fetches via an imem req/ack
//  handshake, decodes, and drives the data path's control strobes. Runs loads and
//  stores via a dmem req/ack handshake, then retires each instruction.
//  Sits between the instruction/data memories and the data path control inputs.
// PARAMETERS
//  ACK_TIMEOUT  16  max cycles a req may wait for ack before TRAP; 0 = no timeout
//  TMO_W        5   width of the timeout counter; must hold ACK_TIMEOUT
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous active-high reset
//  instr        in   32  fetched instruction, valid in the cycle imem_ack=1
//  imem_ack     in   1   instruction memory done
//  dmem_ack     in   1   data memory done
//  br_taken     in   1   branch comparison result from the data path (EXEC only)
//  imem_req     out  1   instruction fetch request
//  dmem_req     out  1   data access request
//  ir_we        out  1   instruction register load strobe
//  pc_we        out  1   PC update strobe
//  pc_src       out  1   0 = PC+4, 1 = branch/jump target
//  reg_write    out  1   register file write strobe
//  dm_write     out  1   data memory write (store) qualifier
//  wd_src       out  1   write-back select: 0 = ALU result, 1 = load data
//  alu_control  out  4   ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9
//  imm_sel      out  3   I0 S1 B2 U3 J4
//  br_sel/dm_sel/store_sel out 3 each  funct3 of the current instruction
//  trap         out  1   sticky: illegal opcode or ack timeout
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs are registered.
//  Reset: state=FETCH, decoded fields=0, timeout count=0, all strobes/reqs/trap=0.
//   Reset has priority over every event. If it arrives mid-handshake, req is
//   deasserted at the next edge and any late ack is ignored.
//  FETCH: imem_req=1 until imem_ack. An ack in the first req cycle counts.
//   On ack: ir_we=1 for 1 cycle -> DECODE.
//  DECODE: registers alu_control, imm_sel, funct3 fields, wd_src from instr.
//   Opcode not in {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP} -> TRAP.
//   Otherwise -> EXEC.
//  EXEC:
//   BRANCH: pc_we=1, pc_src=br_taken -> FETCH.
//   LOAD/STORE -> MEM.
//   All others -> WB.
//  MEM: dmem_req=1 until dmem_ack. dm_write=1 for the whole request on STORE.
//   On ack: LOAD -> WB; STORE -> pc_we=1, pc_src=0 -> FETCH.
//  WB: reg_write=1 for exactly 1 cycle, suppressed when rd==x0.
//   pc_we=1; pc_src=1 for JAL/JALR, else 0 -> FETCH.
//  TRAP: all strobes/reqs=0, trap=1. Exit only via rst.
//  Timeout:
//   - Counter clears on every req rising edge and on ack.
//   - Increments each cycle req=1 and ack=0.
//   - When it reaches ACK_TIMEOUT -> TRAP.
//  Acks arriving while no req is asserted are ignored.
//  Strobe widths: pc_we and ir_we are 1 cycle per instruction; reg_write is at most 1 cycle.
//  Latency with ack in the first req cycle: branch 3, ALU/jump 4, store 4, load 5 cycles.
// TESTING
//  ADDI x1,x0,5 (0x00500093), acks in 1 cycle -> ir_we@1, reg_write+pc_we@4, alu_control=0, imm_sel=0.
//  BEQ taken, br_taken=1 -> pc_we=1 with pc_src=1 in EXEC. No reg_write, no dmem_req.
//  SW, dmem_ack delayed 3 cycles -> dmem_req and dm_write high 4 cycles; pc_we after ack; store_sel=3'b010.
//  LW -> wd_src=1, reg_write in WB 1 cycle after dmem_ack. ADDI rd=x0 -> reg_write stays 0.
//  instr=0x00000000 -> TRAP after DECODE, trap=1 held. imem_ack never arrives -> TRAP after 16 req cycles.
//  rst mid-MEM -> dmem_req=0 next cycle, state=FETCH. Stray dmem_ack in FETCH has no effect.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for an RV32I data path.
// Handles the imem/dmem req/ack handshakes, decodes each instruction and
// drives the data path strobes. Every output is registered.
module cpu_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned TMO_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_write,
    output logic        dm_write,
    output logic        wd_src,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_sel,
    output logic [2:0]  br_sel,
    output logic [2:0]  dm_sel,
    output logic [2:0]  store_sel,
    output logic        trap
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

    state_t           state, state_n;
    logic [6:0]       ir_op, ir_op_n;
    logic [4:0]       ir_rd, ir_rd_n;
    logic [2:0]       ir_f3, ir_f3_n;
    logic             ir_b30, ir_b30_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n, tmo_inc;
    logic             tmo_hit;

    logic       imem_req_n, dmem_req_n, ir_we_n, pc_we_n, pc_src_n;
    logic       reg_write_n, dm_write_n, wd_src_n, trap_n;
    logic [3:0] alu_control_n;
    logic [2:0] imm_sel_n, f3_n;

    logic is_legal, is_branch, is_load, is_store, is_jump;

    // Immediate/register fields are decoded by the data path, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15]};

    // Instruction class flags from the captured opcode
    always_comb begin
        is_branch = (ir_op == OPC_BRANCH);
        is_load   = (ir_op == OPC_LOAD);
        is_store  = (ir_op == OPC_STORE);
        is_jump   = (ir_op == OPC_JAL) || (ir_op == OPC_JALR);
        is_legal  = (ir_op == OPC_LUI)   || (ir_op == OPC_AUIPC) || is_jump || is_branch ||
                    is_load || is_store  || (ir_op == OPC_OPIMM) || (ir_op == OPC_OP);
        tmo_inc   = tmo_cnt + TMO_W'(1);
        tmo_hit   = (ACK_TIMEOUT != 0) && (tmo_inc == TMO_W'(ACK_TIMEOUT));
    end

    // Next-state and next-output logic; pulse strobes default low every cycle
    always_comb begin
        state_n       = state;
        ir_op_n       = ir_op;
        ir_rd_n       = ir_rd;
        ir_f3_n       = ir_f3;
        ir_b30_n      = ir_b30;
        tmo_cnt_n     = tmo_cnt;
        imem_req_n    = 1'b0;
        dmem_req_n    = 1'b0;
        ir_we_n       = 1'b0;
        pc_we_n       = 1'b0;
        pc_src_n      = 1'b0;
        reg_write_n   = 1'b0;
        dm_write_n    = 1'b0;
        trap_n        = 1'b0;
        wd_src_n      = wd_src;
        alu_control_n = alu_control;
        imm_sel_n     = imm_sel;
        f3_n          = br_sel;

        unique case (state)
            FETCH: begin
                if (!imem_req) begin
                    imem_req_n = 1'b1;
                    tmo_cnt_n  = '0;
                end else if (imem_ack) begin
                    ir_op_n   = instr[6:0];
                    ir_rd_n   = instr[11:7];
                    ir_f3_n   = instr[14:12];
                    ir_b30_n  = instr[30];
                    ir_we_n   = 1'b1;
                    tmo_cnt_n = '0;
                    state_n   = DECODE;
                end else if (tmo_hit) begin
                    trap_n  = 1'b1;
                    state_n = TRAP;
                end else begin
                    imem_req_n = 1'b1;
                    tmo_cnt_n  = tmo_inc;
                end
            end
            DECODE: begin
                f3_n     = ir_f3;
                wd_src_n = is_load;
                if (ir_op == OPC_OP || ir_op == OPC_OPIMM) begin
                    unique case (ir_f3)
                        3'b000:  alu_control_n = (ir_op == OPC_OP && ir_b30) ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_control_n = ALU_SLL;
                        3'b010:  alu_control_n = ALU_SLT;
                        3'b011:  alu_control_n = ALU_SLTU;
                        3'b100:  alu_control_n = ALU_XOR;
                        3'b101:  alu_control_n = ir_b30 ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_control_n = ALU_OR;
                        default: alu_control_n = ALU_AND;
                    endcase
                end else if (is_branch) begin
                    alu_control_n = ALU_SUB;
                end else begin
                    alu_control_n = ALU_ADD;
                end
                if (is_store)                                     imm_sel_n = IMM_S;
                else if (is_branch)                               imm_sel_n = IMM_B;
                else if (ir_op == OPC_LUI || ir_op == OPC_AUIPC)  imm_sel_n = IMM_U;
                else if (ir_op == OPC_JAL)                        imm_sel_n = IMM_J;
                else                                              imm_sel_n = IMM_I;
                if (is_legal) begin
                    state_n = EXEC;
                end else begin
                    trap_n  = 1'b1;
                    state_n = TRAP;
                end
            end
            EXEC: begin
                if (is_branch) begin
                    pc_we_n  = 1'b1;
                    pc_src_n = br_taken;
                    state_n  = FETCH;
                end else if (is_load || is_store) begin
                    dmem_req_n = 1'b1;
                    dm_write_n = is_store;
                    tmo_cnt_n  = '0;
                    state_n    = MEM;
                end else begin
                    state_n = WB;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    tmo_cnt_n = '0;
                    if (is_store) begin
                        pc_we_n = 1'b1;
                        state_n = FETCH;
                    end else begin
                        state_n = WB;
                    end
                end else if (tmo_hit) begin
                    trap_n  = 1'b1;
                    state_n = TRAP;
                end else begin
                    dmem_req_n = 1'b1;
                    dm_write_n = is_store;
                    tmo_cnt_n  = tmo_inc;
                end
            end
            WB: begin
                reg_write_n = (ir_rd != 5'd0);
                pc_we_n     = 1'b1;
                pc_src_n    = is_jump;
                state_n     = FETCH;
            end
            default: begin
                trap_n = 1'b1;
            end
        endcase
    end

    // State, captured instruction fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            ir_op       <= '0;
            ir_rd       <= '0;
            ir_f3       <= '0;
            ir_b30      <= 1'b0;
            tmo_cnt     <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            ir_we       <= 1'b0;
            pc_we       <= 1'b0;
            pc_src      <= 1'b0;
            reg_write   <= 1'b0;
            dm_write    <= 1'b0;
            wd_src      <= 1'b0;
            alu_control <= '0;
            imm_sel     <= '0;
            br_sel      <= '0;
            dm_sel      <= '0;
            store_sel   <= '0;
            trap        <= 1'b0;
        end else begin
            state       <= state_n;
            ir_op       <= ir_op_n;
            ir_rd       <= ir_rd_n;
            ir_f3       <= ir_f3_n;
            ir_b30      <= ir_b30_n;
            tmo_cnt     <= tmo_cnt_n;
            imem_req    <= imem_req_n;
            dmem_req    <= dmem_req_n;
            ir_we       <= ir_we_n;
            pc_we       <= pc_we_n;
            pc_src      <= pc_src_n;
            reg_write   <= reg_write_n;
            dm_write    <= dm_write_n;
            wd_src      <= wd_src_n;
            alu_control <= alu_control_n;
            imm_sel     <= imm_sel_n;
            br_sel      <= f3_n;
            dm_sel      <= f3_n;
            store_sel   <= f3_n;
            trap        <= trap_n;
        end
    end

endmodule
